// File: rtl/spi_cs_arbiter.sv
// Two-requester round-robin front end for the 16-bit SPI master: owns the chip selects,
// enforces setup/hold/gap timing and keeps cs_n low across multi-word transactions.
module spi_cs_arbiter #(
    parameter int NCS      = 4,
    parameter int CSW      = 2,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_GAP   = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           a_req,
    input  logic [CSW-1:0] a_cs,
    input  logic [15:0]    a_tx,
    input  logic           a_both,
    input  logic           a_last,
    output logic           a_ack,
    output logic           a_done,
    input  logic           b_req,
    input  logic [CSW-1:0] b_cs,
    input  logic [15:0]    b_tx,
    input  logic           b_both,
    input  logic           b_last,
    output logic           b_ack,
    output logic           b_done,
    output logic [15:0]    rx,
    output logic           m_we,
    output logic           m_both,
    output logic [15:0]    m_tx,
    input  logic [15:0]    m_rx,
    input  logic           m_running,
    output logic [NCS-1:0] cs_n,
    output logic           busy
);

    typedef enum logic [2:0] {
        S_FLUSH, S_IDLE, S_SETUP, S_ISSUE, S_LAUNCH, S_WAIT, S_HOLD, S_GAP
    } state_t;

    localparam int CMAX  = (CS_SETUP > CS_HOLD) ? ((CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP)
                                                : ((CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP);
    localparam int CNT_W = $clog2(CMAX + 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             owner_q, owner_d;          // 0 = A, 1 = B
    logic             last_owner_q, last_owner_d;
    logic [CSW-1:0]   cs_sel_q, cs_sel_d;
    logic             last_q, last_d;
    logic [NCS-1:0]   cs_n_q, cs_n_d;
    logic             m_we_q, m_we_d;
    logic             m_both_q, m_both_d;
    logic [15:0]      m_tx_q, m_tx_d;
    logic             a_ack_q, a_ack_d, b_ack_q, b_ack_d;
    logic             a_done_q, a_done_d, b_done_q, b_done_d;
    logic [15:0]      rx_q, rx_d;
    logic             busy_q, busy_d;

    logic             own_req, own_both, own_last;
    logic [15:0]      own_tx;

    assign own_req  = owner_q ? b_req  : a_req;
    assign own_tx   = owner_q ? b_tx   : a_tx;
    assign own_both = owner_q ? b_both : a_both;
    assign own_last = owner_q ? b_last : a_last;

    // An index with no matching output leaves every select high.
    function automatic logic [NCS-1:0] cs_decode(input logic [CSW-1:0] idx);
        logic [NCS-1:0] r;
        for (int i = 0; i < NCS; i++) begin
            r[i] = (idx != CSW'(i));
        end
        return r;
    endfunction

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        cs_sel_d     = cs_sel_q;
        last_d       = last_q;
        cs_n_d       = cs_n_q;
        m_tx_d       = m_tx_q;
        m_both_d     = m_both_q;
        rx_d         = rx_q;
        m_we_d       = 1'b0;
        a_ack_d      = 1'b0;
        b_ack_d      = 1'b0;
        a_done_d     = 1'b0;
        b_done_d     = 1'b0;

        case (state_q)
            S_FLUSH: begin
                if (!m_running) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (a_req && (!b_req || last_owner_q)) begin
                    owner_d      = 1'b0;
                    last_owner_d = 1'b0;
                    cs_sel_d     = a_cs;
                    cnt_d        = '0;
                    state_d      = S_SETUP;
                end else if (b_req) begin
                    owner_d      = 1'b1;
                    last_owner_d = 1'b1;
                    cs_sel_d     = b_cs;
                    cnt_d        = '0;
                    state_d      = S_SETUP;
                end
            end
            S_SETUP: begin
                cs_n_d = cs_decode(cs_sel_q);
                if (cnt_q == CNT_W'(CS_SETUP - 1)) begin
                    cnt_d   = '0;
                    state_d = S_ISSUE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_ISSUE: begin
                if (!own_req) begin
                    cnt_d   = '0;
                    state_d = S_HOLD;
                end else if (!m_running) begin
                    m_we_d   = 1'b1;
                    m_tx_d   = own_tx;
                    m_both_d = own_both;
                    a_ack_d  = ~owner_q;
                    b_ack_d  = owner_q;
                    last_d   = own_last;
                    state_d  = S_LAUNCH;
                end
            end
            // The master raises m_running only one cycle after it sees m_we.
            S_LAUNCH: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!m_running) begin
                    a_done_d = ~owner_q;
                    b_done_d = owner_q;
                    rx_d     = m_rx;
                    cnt_d    = '0;
                    state_d  = last_q ? S_HOLD : S_ISSUE;
                end
            end
            S_HOLD: begin
                if (cnt_q == CNT_W'(CS_HOLD - 1)) begin
                    cs_n_d  = '1;
                    cnt_d   = '0;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_GAP: begin
                if (cnt_q == CNT_W'(CS_GAP - 1)) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_FLUSH;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_FLUSH;
            cnt_q        <= '0;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            cs_sel_q     <= '0;
            last_q       <= 1'b0;
            cs_n_q       <= '1;
            m_we_q       <= 1'b0;
            m_both_q     <= 1'b0;
            m_tx_q       <= '0;
            a_ack_q      <= 1'b0;
            b_ack_q      <= 1'b0;
            a_done_q     <= 1'b0;
            b_done_q     <= 1'b0;
            rx_q         <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            cs_sel_q     <= cs_sel_d;
            last_q       <= last_d;
            cs_n_q       <= cs_n_d;
            m_we_q       <= m_we_d;
            m_both_q     <= m_both_d;
            m_tx_q       <= m_tx_d;
            a_ack_q      <= a_ack_d;
            b_ack_q      <= b_ack_d;
            a_done_q     <= a_done_d;
            b_done_q     <= b_done_d;
            rx_q         <= rx_d;
            busy_q       <= busy_d;
        end
    end

    assign cs_n   = cs_n_q;
    assign m_we   = m_we_q;
    assign m_both = m_both_q;
    assign m_tx   = m_tx_q;
    assign a_ack  = a_ack_q;
    assign b_ack  = b_ack_q;
    assign a_done = a_done_q;
    assign b_done = b_done_q;
    assign rx     = rx_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_spi_cs_arbiter.sv
// Bench for spi_cs_arbiter: two requester agents, a behavioural SPI master and a
// scoreboard of expected m_tx/m_both and rx values per requester.
module tb_spi_cs_arbiter;

    localparam int NCS      = 3;
    localparam int CSW      = 2;
    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;
    localparam int CS_GAP   = 1;

    typedef struct packed {
        logic [15:0]    tx;
        logic           both;
        logic           last;
        logic [CSW-1:0] cs;
    } word_t;

    logic           clk, rst;
    logic           a_req, a_both, a_last, a_ack, a_done;
    logic [CSW-1:0] a_cs;
    logic [15:0]    a_tx;
    logic           b_req, b_both, b_last, b_ack, b_done;
    logic [CSW-1:0] b_cs;
    logic [15:0]    b_tx;
    logic [15:0]    rx, m_tx;
    logic           m_we, m_both;
    logic [15:0]    m_rx      = '0;
    logic           m_running = 1'b0;
    logic [NCS-1:0] cs_n;
    logic           busy;

    int passed = 0;
    int total  = 0;
    int acks_a = 0, acks_b = 0, dones_a = 0, dones_b = 0;

    word_t       qa[$], qb[$];
    logic [16:0] exp_we_a[$], exp_we_b[$];
    logic [15:0] exp_rx_a[$], exp_rx_b[$];
    logic        ack_log[$];

    spi_cs_arbiter #(
        .NCS(NCS), .CSW(CSW), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_GAP(CS_GAP)
    ) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_cs(a_cs), .a_tx(a_tx), .a_both(a_both), .a_last(a_last),
        .a_ack(a_ack), .a_done(a_done),
        .b_req(b_req), .b_cs(b_cs), .b_tx(b_tx), .b_both(b_both), .b_last(b_last),
        .b_ack(b_ack), .b_done(b_done),
        .rx(rx), .m_we(m_we), .m_both(m_both), .m_tx(m_tx), .m_rx(m_rx),
        .m_running(m_running), .cs_n(cs_n), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // SPI master model (no reset): busy for a fixed time per word, slave answers tx ^ A5A5.
    int          xcnt = 0;
    logic [15:0] sh   = '0;
    always @(posedge clk) begin
        if (m_running) begin
            if (xcnt == 1) begin
                m_running <= 1'b0;
                m_rx      <= sh ^ 16'hA5A5;
            end
            xcnt <= xcnt - 1;
        end else if (m_we) begin
            m_running <= 1'b1;
            xcnt      <= m_both ? 6 : 3;
            sh        <= m_tx;
        end
    end

    // Requester agents: hold req until ack, then present the next queued word or drop req.
    initial begin
        word_t w;
        a_req = 0; a_cs = '0; a_tx = '0; a_both = 0; a_last = 0;
        b_req = 0; b_cs = '0; b_tx = '0; b_both = 0; b_last = 0;
        forever begin
            @(negedge clk);
            if (a_req && a_ack) a_req = 0;
            if (!a_req && qa.size() != 0) begin
                w = qa.pop_front();
                a_req = 1; a_tx = w.tx; a_both = w.both; a_last = w.last; a_cs = w.cs;
                exp_we_a.push_back({w.both, w.tx});
                exp_rx_a.push_back(w.tx ^ 16'hA5A5);
            end
            if (b_req && b_ack) b_req = 0;
            if (!b_req && qb.size() != 0) begin
                w = qb.pop_front();
                b_req = 1; b_tx = w.tx; b_both = w.both; b_last = w.last; b_cs = w.cs;
                exp_we_b.push_back({w.both, w.tx});
                exp_rx_b.push_back(w.tx ^ 16'hA5A5);
            end
        end
    end

    // Scoreboard and protocol monitor.
    always @(negedge clk) begin : mon
        if (!rst) begin
            if (a_ack || b_ack) begin
                chk("ack_with_we", 32'(m_we), 1);
                chk("ack_single", 32'(a_ack & b_ack), 0);
                ack_log.push_back(b_ack);
                if (a_ack) acks_a++;
                else acks_b++;
            end
            if (m_we) begin
                chk("we_not_running", 32'(m_running), 0);
                chk("we_has_ack", 32'(a_ack | b_ack), 1);
                if (a_ack) begin
                    chk("we_a_expected", 32'(exp_we_a.size() != 0), 1);
                    if (exp_we_a.size() != 0)
                        chk("m_both_tx_a", 32'({m_both, m_tx}), 32'(exp_we_a.pop_front()));
                end else if (b_ack) begin
                    chk("we_b_expected", 32'(exp_we_b.size() != 0), 1);
                    if (exp_we_b.size() != 0)
                        chk("m_both_tx_b", 32'({m_both, m_tx}), 32'(exp_we_b.pop_front()));
                end
            end
            if (a_done) begin
                dones_a++;
                chk("a_done_expected", 32'(exp_rx_a.size() != 0), 1);
                if (exp_rx_a.size() != 0) chk("rx_a", 32'(rx), 32'(exp_rx_a.pop_front()));
            end
            if (b_done) begin
                dones_b++;
                chk("b_done_expected", 32'(exp_rx_b.size() != 0), 1);
                if (exp_rx_b.size() != 0) chk("rx_b", 32'(rx), 32'(exp_rx_b.pop_front()));
            end
            if (cs_n != '1) chk("cs_one_low", $countones(~cs_n), 1);
        end
    end

    function automatic int order2();
        if (ack_log.size() != 2) return 99;
        return int'({ack_log[0], ack_log[1]});
    endfunction

    task automatic wait_dones(input int na, input int nb, input string tag);
        int seen = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (dones_a >= na && dones_b >= nb) begin seen = 1; break; end
        end
        chk(tag, seen, 1);
    endtask

    task automatic wait_idle(input string tag);
        int seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) begin seen = 1; break; end
        end
        chk(tag, seen, 1);
    endtask

    task automatic wait_a_done(input string tag);
        int seen = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (a_done) begin seen = 1; break; end
        end
        chk(tag, seen, 1);
    endtask

    task automatic count_to_cs_high(output int n);
        n = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            n++;
            if (cs_n == '1) break;
        end
    endtask

    initial begin : main
        int n, seen, bad, gap, hcnt, low_seen, da, db, aa, guard;
        logic [NCS-1:0] cs_at_we;

        rst = 1;
        repeat (3) @(negedge clk);
        chk("rst_cs_n", 32'(cs_n), 32'(3'b111));
        chk("rst_ctrl", 32'({m_we, a_ack, b_ack, a_done, b_done, busy, m_both}), 0);
        chk("rst_m_tx", 32'(m_tx), 0);
        rst = 0;
        repeat (2) @(negedge clk);

        // Single word on cs 1: setup length, then hold length after done.
        qa.push_back('{16'h12AB, 1'b1, 1'b1, 2'd1});
        n = 0; seen = 0; cs_at_we = '1;
        for (int i = 0; i < 100 && seen == 0; i++) begin
            @(negedge clk);
            if (m_we) begin seen = 1; cs_at_we = cs_n; end
            else if (cs_n == 3'b101) n++;
        end
        chk("t1_we_seen", seen, 1);
        chk("t1_setup_cycles", n, CS_SETUP);
        chk("t1_cs_at_we", 32'(cs_at_we), 32'(3'b101));
        wait_a_done("t1_done_seen");
        count_to_cs_high(n);
        chk("t1_hold_cycles", n, CS_HOLD);
        wait_idle("t1_idle");
        chk("t1_ack_count", acks_a, 1);
        chk("t1_done_count", dones_a, 1);

        // Three-word burst: cs 1 low continuously until the third done.
        da = dones_a; aa = acks_a;
        qa.push_back('{16'h0001, 1'b1, 1'b0, 2'd1});
        qa.push_back('{16'hBEEF, 1'b1, 1'b0, 2'd1});
        qa.push_back('{16'h5A5A, 1'b1, 1'b1, 2'd1});
        seen = 0;
        for (int i = 0; i < 100 && seen == 0; i++) begin
            @(negedge clk);
            if (cs_n != '1) seen = 1;
        end
        chk("t2_cs_fell", seen, 1);
        bad = 0; seen = 0;
        for (int i = 0; i < 500 && seen < 3; i++) begin
            @(negedge clk);
            if (cs_n != 3'b101) bad++;
            if (a_done) seen++;
        end
        chk("t2_cs_continuous", bad, 0);
        chk("t2_done_seen", seen, 3);
        wait_idle("t2_idle");
        chk("t2_ack_count", acks_a - aa, 3);

        // Contention straight out of reset: A first, then B after an all-high gap.
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        ack_log.delete();
        da = dones_a; db = dones_b;
        qa.push_back('{16'h0A0A, 1'b1, 1'b1, 2'd0});
        qb.push_back('{16'hB0B0, 1'b0, 1'b1, 2'd2});
        gap = -1; hcnt = 0; low_seen = 0; seen = 0;
        for (int i = 0; i < 600 && seen == 0; i++) begin
            @(negedge clk);
            if (cs_n == '1) hcnt++;
            else begin
                if (low_seen != 0 && hcnt > 0 && gap < 0) gap = hcnt;
                hcnt = 0; low_seen = 1;
            end
            if (b_done) seen = 1;
        end
        chk("t3_b_done_seen", seen, 1);
        chk("t3_gap_min", 32'(gap >= CS_GAP), 1);
        wait_idle("t3_idle");
        chk("t3_order_a_then_b", order2(), 1);

        // Both again: B owned last, so A wins.
        ack_log.delete();
        da = dones_a; db = dones_b;
        qa.push_back('{16'h1111, 1'b1, 1'b1, 2'd0});
        qb.push_back('{16'h2222, 1'b1, 1'b1, 2'd2});
        wait_dones(da + 1, db + 1, "t3b_dones");
        wait_idle("t3b_idle");
        chk("t3b_order_a_then_b", order2(), 1);

        // A alone, then both: round robin hands B the next tie.
        da = dones_a;
        qa.push_back('{16'h3333, 1'b1, 1'b1, 2'd0});
        wait_dones(da + 1, 0, "t3c_a_done");
        wait_idle("t3c_idle");
        ack_log.delete();
        da = dones_a; db = dones_b;
        qa.push_back('{16'h4444, 1'b1, 1'b1, 2'd0});
        qb.push_back('{16'h5555, 1'b0, 1'b1, 2'd2});
        wait_dones(da + 1, db + 1, "t3d_dones");
        wait_idle("t3d_idle");
        chk("t3d_order_b_then_a", order2(), 2);

        // Abort: A drops req after a non-last word; B is waiting.
        ack_log.delete();
        aa = acks_a; da = dones_a; db = dones_b;
        qa.push_back('{16'h3C3C, 1'b1, 1'b0, 2'd0});
        seen = 0;
        for (int i = 0; i < 100 && seen == 0; i++) begin
            @(negedge clk);
            if (a_ack) seen = 1;
        end
        chk("t4_a_ack_seen", seen, 1);
        qb.push_back('{16'h6789, 1'b1, 1'b1, 2'd2});
        wait_a_done("t4_a_done_seen");
        count_to_cs_high(n);
        // Abort is seen in ISSUE, one cycle after done, before the hold count starts.
        chk("t4_abort_hold", n, CS_HOLD + 1);
        wait_dones(0, db + 1, "t4_b_done");
        wait_idle("t4_idle");
        chk("t4_a_acks", acks_a - aa, 1);
        chk("t4_a_dones", dones_a - da, 1);
        chk("t4_order_a_then_b", order2(), 1);

        // Reset while the master is mid-transfer.
        da = dones_a; db = dones_b;
        qa.push_back('{16'h7E81, 1'b1, 1'b1, 2'd0});
        seen = 0;
        for (int i = 0; i < 100 && seen == 0; i++) begin
            @(negedge clk);
            if (m_running) seen = 1;
        end
        chk("t5_running_seen", seen, 1);
        rst = 1;
        @(negedge clk);
        chk("t5_cs_high_after_rst", 32'(cs_n), 32'(3'b111));
        chk("t5_ctrl_after_rst", 32'({busy, a_ack, a_done, m_we}), 0);
        rst = 0;
        exp_rx_a.delete();
        qb.push_back('{16'h4242, 1'b1, 1'b1, 2'd2});
        bad = 0; guard = 0;
        while (m_running && guard < 100) begin
            @(negedge clk);
            guard++;
            if (cs_n != '1 || b_ack) bad++;
        end
        chk("t5_flush_no_grant", bad, 0);
        chk("t5_flush_ended", 32'(m_running), 0);
        wait_dones(0, db + 1, "t5_b_done");
        wait_idle("t5_idle");
        chk("t5_no_a_done", dones_a - da, 0);

        // Out-of-range cs with an 8-bit transfer: no select drops, word still completes.
        da = dones_a;
        qa.push_back('{16'h00C3, 1'b0, 1'b1, 2'd3});
        bad = 0; seen = 0;
        for (int i = 0; i < 300 && seen == 0; i++) begin
            @(negedge clk);
            if (cs_n != '1) bad++;
            if (a_done) seen = 1;
        end
        chk("t6_done_seen", seen, 1);
        chk("t6_cs_all_high", bad, 0);
        wait_idle("t6_idle");
        chk("t6_cs_high_idle", 32'(cs_n), 32'(3'b111));
        chk("t6_done_count", dones_a - da, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
